gcd_controller: RTL

Control-path FSM for the 16-bit subtractive GCD engine. Accepts two operands from an upstream producer over a valid/ready handshake, steers them into the GCD datapath's A and B registers, then drives repeated subtract-and-reload cycles from the datapath's lt/gt/eq flags until A equals B. Signals completion with a one-cycle `done` pulse, at which point the datapath A register holds the result. Also guards against non-terminating operand pairs with an iteration limit.

---
 rtl/gcd_controller.sv | 115 +++++++++++
 1 files changed

// File: rtl/gcd_controller.sv
// rtl/gcd_controller.sv - control FSM for the 16-bit subtractive GCD datapath
module gcd_controller #(
  parameter int CNT_W    = 16,
  parameter int MAX_ITER = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             lt,
  input  logic             gt,
  input  logic             eq,
  output logic             ldA,
  output logic             ldB,
  output logic             sel_in,
  output logic             sel1,
  output logic             sel2,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] iter_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOADA = 3'd1,
    S_LOADB = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] MaxIter = CNT_W'(MAX_ITER);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] iter_q, iter_d;

  // State and iteration counter registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  // Next-state and datapath steering; a RUN cycle with no flag set is taken as equal.
  always_comb begin
    state_d  = state_q;
    iter_d   = iter_q;
    ldA      = 1'b0;
    ldB      = 1'b0;
    sel_in   = 1'b0;
    sel1     = 1'b0;
    sel2     = 1'b0;
    in_ready = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOADA;
          iter_d  = '0;
        end
      end
      S_LOADA: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ldA     = 1'b1;
          state_d = S_LOADB;
        end
      end
      S_LOADB: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ldB     = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (eq || (!lt && !gt)) begin
          state_d = S_DONE;
        end else if (iter_q == MaxIter) begin
          state_d = S_ERR;
        end else if (gt) begin
          sel1   = 1'b1;
          sel_in = 1'b1;
          ldA    = 1'b1;
          iter_d = iter_q + 1'b1;
        end else begin
          sel2   = 1'b1;
          sel_in = 1'b1;
          ldB    = 1'b1;
          iter_d = iter_q + 1'b1;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        err     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign iter_count = iter_q;

endmodule
